// File: rtl/char_src_arbiter.sv
// Two-source character arbiter. Keyboard and UART bytes each go into their own FIFO and are
// merged onto one registered valid/ready output. Grants alternate and are capped by a burst limit.
module char_src_arbiter #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned BURST_MAX = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] kbdData,
    input  logic       kbdDataValid,
    input  logic [7:0] uartData,
    input  logic       uartDataValid,
    output logic [7:0] outData,
    output logic       outValid,
    input  logic       outReady,
    output logic       outSrc,
    output logic       kbdOverflow,
    output logic       uartOverflow,
    input  logic       clrOverflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [3:0] BMAX = 4'(BURST_MAX);

    typedef enum logic [1:0] {IDLE, GNT_KBD, GNT_UART} state_t;

    state_t      state;
    logic        last_grant;
    logic [3:0]  burst_cnt;

    logic [7:0]    kbd_mem [DEPTH];
    logic [AW-1:0] kbd_wptr, kbd_rptr;
    logic [CW-1:0] kbd_cnt, kbd_cnt_nxt;
    logic          kbd_push, kbd_pop, kbd_drop;

    logic [7:0]    uart_mem [DEPTH];
    logic [AW-1:0] uart_wptr, uart_rptr;
    logic [CW-1:0] uart_cnt, uart_cnt_nxt;
    logic          uart_push, uart_pop, uart_drop;

    logic          gnt_src;
    logic          load;
    logic [7:0]    head;
    logic [3:0]    burst_nxt;
    logic [CW-1:0] own_nxt, other_nxt;
    logic          grant_end;

    always_comb begin
        gnt_src = (state == GNT_UART);
        load    = 1'b0;
        if ((state == GNT_KBD && kbd_cnt != '0) || (state == GNT_UART && uart_cnt != '0)) begin
            load = !outValid || outReady;
        end
        kbd_pop  = load && (state == GNT_KBD);
        uart_pop = load && (state == GNT_UART);

        // A pop at the same edge frees a slot, so a full FIFO can still accept the strobe.
        kbd_push  = kbdDataValid && ((kbd_cnt != FULL) || kbd_pop);
        kbd_drop  = kbdDataValid && (kbd_cnt == FULL) && !kbd_pop;
        uart_push = uartDataValid && ((uart_cnt != FULL) || uart_pop);
        uart_drop = uartDataValid && (uart_cnt == FULL) && !uart_pop;

        kbd_cnt_nxt  = kbd_cnt + CW'(kbd_push) - CW'(kbd_pop);
        uart_cnt_nxt = uart_cnt + CW'(uart_push) - CW'(uart_pop);

        head      = gnt_src ? uart_mem[uart_rptr] : kbd_mem[kbd_rptr];
        burst_nxt = burst_cnt + {3'b000, load};
        own_nxt   = gnt_src ? uart_cnt_nxt : kbd_cnt_nxt;
        other_nxt = gnt_src ? kbd_cnt_nxt : uart_cnt_nxt;
        grant_end = (own_nxt == '0) || (burst_nxt == BMAX);
    end

    // FIFO storage carries no reset; only pointers and counts define its contents.
    always_ff @(posedge clk) begin
        if (kbd_push) begin
            kbd_mem[kbd_wptr] <= kbdData;
        end
        if (uart_push) begin
            uart_mem[uart_wptr] <= uartData;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            kbd_wptr     <= '0;
            kbd_rptr     <= '0;
            kbd_cnt      <= '0;
            uart_wptr    <= '0;
            uart_rptr    <= '0;
            uart_cnt     <= '0;
            kbdOverflow  <= 1'b0;
            uartOverflow <= 1'b0;
        end else begin
            if (kbd_push) begin
                kbd_wptr <= kbd_wptr + AW'(1);
            end
            if (kbd_pop) begin
                kbd_rptr <= kbd_rptr + AW'(1);
            end
            kbd_cnt <= kbd_cnt_nxt;
            if (uart_push) begin
                uart_wptr <= uart_wptr + AW'(1);
            end
            if (uart_pop) begin
                uart_rptr <= uart_rptr + AW'(1);
            end
            uart_cnt <= uart_cnt_nxt;

            // A drop at the same edge as a clear wins.
            if (kbd_drop) begin
                kbdOverflow <= 1'b1;
            end else if (clrOverflow) begin
                kbdOverflow <= 1'b0;
            end
            if (uart_drop) begin
                uartOverflow <= 1'b1;
            end else if (clrOverflow) begin
                uartOverflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            burst_cnt  <= 4'd0;
            outValid   <= 1'b0;
            outData    <= 8'h00;
            outSrc     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    burst_cnt <= 4'd0;
                    if (kbd_cnt != '0 && (uart_cnt == '0 || last_grant)) begin
                        state      <= GNT_KBD;
                        last_grant <= 1'b0;
                    end else if (uart_cnt != '0) begin
                        state      <= GNT_UART;
                        last_grant <= 1'b1;
                    end
                end
                GNT_KBD, GNT_UART: begin
                    if (grant_end) begin
                        burst_cnt <= 4'd0;
                        if (other_nxt != '0) begin
                            state      <= gnt_src ? GNT_KBD : GNT_UART;
                            last_grant <= !gnt_src;
                        end else if (own_nxt == '0) begin
                            state <= IDLE;
                        end
                    end else begin
                        burst_cnt <= burst_nxt;
                    end
                end
                default: begin
                    state     <= IDLE;
                    burst_cnt <= 4'd0;
                end
            endcase

            if (load) begin
                outData  <= head;
                outSrc   <= gnt_src;
                outValid <= 1'b1;
            end else if (outValid && outReady) begin
                outValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_char_src_arbiter.sv
// Scoreboard bench for char_src_arbiter: expected {src,data} pushed when stimulus is driven,
// popped at each output handshake.
module tb_char_src_arbiter;

    localparam int DEPTH     = 8;
    localparam int BURST_MAX = 4;

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] kbdData, uartData, outData;
    logic       kbdDataValid, uartDataValid, outValid, outReady, outSrc;
    logic       kbdOverflow, uartOverflow, clrOverflow;

    int total = 0;
    int bad   = 0;
    logic [8:0] sb [$];

    always #5 clk = ~clk;

    char_src_arbiter #(.DEPTH(DEPTH), .BURST_MAX(BURST_MAX)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .kbdData      (kbdData),
        .kbdDataValid (kbdDataValid),
        .uartData     (uartData),
        .uartDataValid(uartDataValid),
        .outData      (outData),
        .outValid     (outValid),
        .outReady     (outReady),
        .outSrc       (outSrc),
        .kbdOverflow  (kbdOverflow),
        .uartOverflow (uartOverflow),
        .clrOverflow  (clrOverflow)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic kv, input logic [7:0] kd, input logic uv, input logic [7:0] ud);
        kbdDataValid  = kv;
        kbdData       = kd;
        uartDataValid = uv;
        uartData      = ud;
        tick();
        kbdDataValid  = 1'b0;
        uartDataValid = 1'b0;
    endtask

    task automatic do_reset;
        #2 resetn = 1'b0;
        sb.delete();
        tick();
        tick();
        #2 resetn = 1'b1;
        tick();
    endtask

    task automatic drain;
        int n = 0;
        while ((sb.size() != 0 || outValid) && n < 200) begin
            tick();
            n++;
        end
        chk("drain_left", sb.size(), 0);
    endtask

    // Strobe at edge N into an idle design: output valid only after edge N+2, for one cycle.
    task automatic latency_check(input logic [7:0] d);
        sb.push_back({1'b0, d});
        drive(1'b1, d, 1'b0, 8'h00);
        chk("lat_n0", outValid, 1'b0);
        tick();
        chk("lat_n1", outValid, 1'b0);
        tick();
        chk("lat_n2_valid", outValid, 1'b1);
        chk("lat_n2_data", outData, d);
        chk("lat_n2_src", outSrc, 1'b0);
        tick();
        chk("lat_n3_valid", outValid, 1'b0);
    endtask

    always @(negedge clk) begin
        if (resetn && outValid && outReady) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", {23'd0, outSrc, outData}, 32'hdead);
            end else begin
                logic [8:0] e;
                e = sb.pop_front();
                chk("out_src", outSrc, e[8]);
                chk("out_data", outData, e[7:0]);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        resetn        = 1'b0;
        kbdData       = 8'h00;
        uartData      = 8'h00;
        kbdDataValid  = 1'b0;
        uartDataValid = 1'b0;
        outReady      = 1'b1;
        clrOverflow   = 1'b0;
        tick();
        tick();
        chk("rst_valid", outValid, 1'b0);
        chk("rst_data", outData, 8'h00);
        chk("rst_src", outSrc, 1'b0);
        chk("rst_kovf", kbdOverflow, 1'b0);
        chk("rst_uovf", uartOverflow, 1'b0);
        #2 resetn = 1'b1;
        tick();

        // Single keyboard byte latency.
        latency_check(8'h41);
        drain();

        // Simultaneous pairs: keyboard first after reset; the second pair arrives while UART
        // holds the grant, so UART continues before keyboard is served again.
        do_reset();
        sb.push_back({1'b0, 8'h61});
        sb.push_back({1'b1, 8'h62});
        drive(1'b1, 8'h61, 1'b1, 8'h62);
        tick();
        tick();
        sb.push_back({1'b1, 8'h64});
        sb.push_back({1'b0, 8'h63});
        drive(1'b1, 8'h63, 1'b1, 8'h64);
        drain();

        // Keyboard burst of four with a UART byte arriving in the middle.
        do_reset();
        for (int i = 0; i < 4; i++) sb.push_back({1'b0, 8'h20 + 8'(i)});
        sb.push_back({1'b1, 8'h55});
        drive(1'b1, 8'h20, 1'b0, 8'h00);
        drive(1'b1, 8'h21, 1'b1, 8'h55);
        drive(1'b1, 8'h22, 1'b0, 8'h00);
        drive(1'b1, 8'h23, 1'b0, 8'h00);
        drain();

        // Overflow: hold a UART byte in the output so the keyboard FIFO fills to DEPTH.
        do_reset();
        outReady = 1'b0;
        sb.push_back({1'b1, 8'h77});
        drive(1'b0, 8'h00, 1'b1, 8'h77);
        tick();
        tick();
        chk("hold_loaded", outValid, 1'b1);
        for (int i = 0; i < 9; i++) begin
            if (i < 8) sb.push_back({1'b0, 8'h30 + 8'(i)});
            drive(1'b1, 8'h30 + 8'(i), 1'b0, 8'h00);
            if (i == 7) chk("kovf_before_9th", kbdOverflow, 1'b0);
            if (i == 8) chk("kovf_after_9th", kbdOverflow, 1'b1);
        end
        for (int i = 0; i < 3; i++) begin
            chk("hold_data", outData, 8'h77);
            chk("hold_src", outSrc, 1'b1);
            chk("hold_valid", outValid, 1'b1);
            tick();
        end
        clrOverflow = 1'b1;
        drive(1'b1, 8'h39, 1'b0, 8'h00);
        chk("kovf_clr_vs_drop", kbdOverflow, 1'b1);
        tick();
        clrOverflow = 1'b0;
        chk("kovf_cleared", kbdOverflow, 1'b0);
        chk("uovf_clear", uartOverflow, 1'b0);
        outReady = 1'b1;
        drain();
        chk("kovf_stays_clear", kbdOverflow, 1'b0);

        // Six bytes per source: K4 U4 K2 U2.
        do_reset();
        for (int i = 0; i < 4; i++) sb.push_back({1'b0, 8'h10 + 8'(i)});
        for (int i = 0; i < 4; i++) sb.push_back({1'b1, 8'h80 + 8'(i)});
        for (int i = 4; i < 6; i++) sb.push_back({1'b0, 8'h10 + 8'(i)});
        for (int i = 4; i < 6; i++) sb.push_back({1'b1, 8'h80 + 8'(i)});
        for (int i = 0; i < 6; i++) drive(1'b1, 8'h10 + 8'(i), 1'b1, 8'h80 + 8'(i));
        drain();

        // Asynchronous reset with a held output and both FIFOs loaded.
        outReady = 1'b0;
        for (int i = 0; i < 3; i++) drive(1'b1, 8'hA0 + 8'(i), 1'b1, 8'hB0 + 8'(i));
        tick();
        tick();
        chk("pre_rst_valid", outValid, 1'b1);
        #2 resetn = 1'b0;
        sb.delete();
        #1;
        chk("async_rst_valid", outValid, 1'b0);
        chk("async_rst_data", outData, 8'h00);
        drive(1'b1, 8'hEE, 1'b1, 8'hEF);
        #2 resetn = 1'b1;
        outReady = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) tick();
        chk("no_stale_valid", outValid, 1'b0);
        latency_check(8'h42);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
